// File: rtl/misaligned_load_seq_if.sv
// Load-request, memory-beat and result signals of the misaligned load sequencer.
// master: LSU pipeline and memory side; slave: the sequencer.
interface misaligned_load_seq_if #(
  parameter int unsigned LLEN = 64,
  parameter int unsigned ADRW = 32,
  parameter int unsigned OFFW = $clog2(LLEN/8)
);
  logic            LoadValid;
  logic            LoadReady;
  logic [ADRW-1:0] LoadAdr;
  logic [1:0]      LoadSize;
  logic            Flush;
  logic            MemReq;
  logic [ADRW-1:0] MemAdr;
  logic            MemGnt;
  logic            MemRspValid;
  logic [LLEN-1:0] MemRspData;
  logic            DataValid;
  logic [LLEN-1:0] DataWord;
  logic [OFFW-1:0] DataOffset;
  logic            DataErr;
  logic [15:0]     SplitCount;

  modport master (
    output LoadValid, LoadAdr, LoadSize, Flush, MemGnt, MemRspValid, MemRspData,
    input  LoadReady, MemReq, MemAdr, DataValid, DataWord, DataOffset, DataErr, SplitCount
  );

  modport slave (
    input  LoadValid, LoadAdr, LoadSize, Flush, MemGnt, MemRspValid, MemRspData,
    output LoadReady, MemReq, MemAdr, DataValid, DataWord, DataOffset, DataErr, SplitCount
  );
endinterface

// File: rtl/misaligned_load_seq.sv
// Splits loads that cross an LLEN/8-byte boundary into two aligned beats and
// merges them into one little-endian word; single-beat loads pass through.
module misaligned_load_seq #(
  parameter int unsigned LLEN = 64,
  parameter int unsigned ADRW = 32,
  parameter int unsigned OFFW = $clog2(LLEN/8)
) (
  input  logic                 clk,
  input  logic                 reset,
  misaligned_load_seq_if.slave bus
);

  localparam int unsigned B   = LLEN/8;
  localparam int unsigned SZW = 8;

  typedef enum logic [2:0] {IDLE, REQ, RSP, DONE, DRAIN} state_t;

  state_t          state, state_nxt;
  logic            accept, rsp_take;
  logic            load_ready, mem_req, data_valid;
  logic [OFFW-1:0] off_in, off_q, data_off;
  logic [SZW-1:0]  nbytes;
  logic            illegal_in, split_in, split_q, beat_q, last_beat;
  logic [ADRW-1:0] mem_adr;
  logic [LLEN-1:0] lo_q, data_word, merged;
  logic            data_err;
  logic [15:0]     split_count;

  // request decode at acceptance
  assign off_in     = bus.LoadAdr[OFFW-1:0];
  assign nbytes     = SZW'(1) << bus.LoadSize;
  assign illegal_in = nbytes > SZW'(B);
  assign split_in   = !illegal_in && ((SZW'(off_in) + nbytes) > SZW'(B));
  assign last_beat  = beat_q || !split_q;
  assign merged     = LLEN'({bus.MemRspData, lo_q} >> {off_q, 3'b000});

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    rsp_take   = 1'b0;
    load_ready = 1'b0;
    mem_req    = 1'b0;
    data_valid = 1'b0;
    case (state)
      IDLE: begin
        load_ready = 1'b1;
        if (bus.LoadValid && !bus.Flush) begin
          accept    = 1'b1;
          state_nxt = illegal_in ? DONE : REQ;
        end
      end
      REQ: begin
        mem_req = 1'b1;
        if (bus.Flush)       state_nxt = bus.MemGnt ? DRAIN : IDLE;
        else if (bus.MemGnt) state_nxt = RSP;
      end
      RSP: begin
        // a response coinciding with Flush is the one being flushed
        if (bus.MemRspValid) begin
          if (bus.Flush) begin
            state_nxt = IDLE;
          end else begin
            rsp_take  = 1'b1;
            state_nxt = last_beat ? DONE : REQ;
          end
        end else if (bus.Flush) begin
          state_nxt = DRAIN;
        end
      end
      DONE: begin
        data_valid = 1'b1;
        state_nxt  = IDLE;
      end
      DRAIN: begin
        if (bus.MemRspValid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      off_q       <= '0;
      split_q     <= 1'b0;
      beat_q      <= 1'b0;
      mem_adr     <= '0;
      lo_q        <= '0;
      data_word   <= '0;
      data_off    <= '0;
      data_err    <= 1'b0;
      split_count <= '0;
    end else begin
      if (accept) begin
        off_q    <= off_in;
        split_q  <= split_in;
        beat_q   <= 1'b0;
        mem_adr  <= {bus.LoadAdr[ADRW-1:OFFW], OFFW'(0)};
        data_err <= illegal_in;
        if (illegal_in) begin
          data_word <= '0;
          data_off  <= '0;
        end
      end
      if (rsp_take) begin
        if (!last_beat) begin
          lo_q    <= bus.MemRspData;
          beat_q  <= 1'b1;
          mem_adr <= mem_adr + ADRW'(B);
        end else begin
          data_word <= split_q ? merged : bus.MemRspData;
          data_off  <= split_q ? '0 : off_q;
        end
      end
      if (state == DONE && split_q && split_count != 16'hFFFF)
        split_count <= split_count + 16'd1;
    end
  end

  assign bus.LoadReady  = load_ready;
  assign bus.MemReq     = mem_req;
  assign bus.MemAdr     = mem_adr;
  assign bus.DataValid  = data_valid;
  assign bus.DataWord   = data_word;
  assign bus.DataOffset = data_off;
  assign bus.DataErr    = data_err;
  assign bus.SplitCount = split_count;

endmodule

// File: tb/tb_misaligned_load_seq.sv
// Directed bench for misaligned_load_seq: 64-bit instance for the main flows,
// 32-bit instance for the illegal-size case.
module tb_misaligned_load_seq;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  misaligned_load_seq_if #(.LLEN(64), .ADRW(32)) m ();
  misaligned_load_seq_if #(.LLEN(32), .ADRW(32)) n ();

  misaligned_load_seq #(.LLEN(64), .ADRW(32)) dut   (.clk(clk), .reset(reset), .bus(m));
  misaligned_load_seq #(.LLEN(32), .ADRW(32)) dut32 (.clk(clk), .reset(reset), .bus(n));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [31:0] adr, input logic [1:0] size);
    m.LoadValid = 1'b1;
    m.LoadAdr   = adr;
    m.LoadSize  = size;
    step();
    m.LoadValid = 1'b0;
  endtask

  // entered in REQ; holds MemGnt low for gnt_wait cycles, then zero-wait response
  task automatic beat(input string tag, input logic [31:0] adr, input int gnt_wait,
                      input logic [63:0] data);
    for (int i = 0; i < gnt_wait; i++) begin
      chk({tag, "_req_hold"}, 64'(m.MemReq), 64'd1);
      chk({tag, "_adr_hold"}, 64'(m.MemAdr), 64'(adr));
      step();
    end
    chk({tag, "_req"}, 64'(m.MemReq), 64'd1);
    chk({tag, "_adr"}, 64'(m.MemAdr), 64'(adr));
    m.MemGnt = 1'b1;
    step();
    m.MemGnt = 1'b0;
    chk({tag, "_rsp_noreq"}, 64'(m.MemReq), 64'd0);
    m.MemRspValid = 1'b1;
    m.MemRspData  = data;
    step();
    m.MemRspValid = 1'b0;
  endtask

  localparam logic [63:0] D_LO = 64'h0706050403020100;
  localparam logic [63:0] D_HI = 64'h0F0E0D0C0B0A0908;

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    m.LoadValid = 1'b0; m.LoadAdr = '0; m.LoadSize = '0; m.Flush = 1'b0;
    m.MemGnt = 1'b0; m.MemRspValid = 1'b0; m.MemRspData = '0;
    n.LoadValid = 1'b0; n.LoadAdr = '0; n.LoadSize = '0; n.Flush = 1'b0;
    n.MemGnt = 1'b0; n.MemRspValid = 1'b0; n.MemRspData = '0;
    step();
    step();
    reset = 1'b0;

    chk("rst_ready", 64'(m.LoadReady),  64'd1);
    chk("rst_req",   64'(m.MemReq),     64'd0);
    chk("rst_adr",   64'(m.MemAdr),     64'd0);
    chk("rst_dv",    64'(m.DataValid),  64'd0);
    chk("rst_word",  64'(m.DataWord),   64'd0);
    chk("rst_off",   64'(m.DataOffset), 64'd0);
    chk("rst_err",   64'(m.DataErr),    64'd0);
    chk("rst_cnt",   64'(m.SplitCount), 64'd0);

    // aligned lw at 0x1004: DataValid in cycle 3, LoadReady in cycle 4
    start(32'h1004, 2'd2);
    chk("al_busy", 64'(m.LoadReady), 64'd0);
    beat("al", 32'h1000, 0, 64'h1122334455667788);
    chk("al_dv",   64'(m.DataValid),  64'd1);
    chk("al_word", 64'(m.DataWord),   64'h1122334455667788);
    chk("al_off",  64'(m.DataOffset), 64'd4);
    chk("al_err",  64'(m.DataErr),    64'd0);
    step();
    chk("al_dv_end", 64'(m.DataValid),  64'd0);
    chk("al_ready",  64'(m.LoadReady),  64'd1);
    chk("al_cnt",    64'(m.SplitCount), 64'd0);

    // split ld at 0x1005
    start(32'h1005, 2'd3);
    beat("sp0", 32'h1000, 0, D_LO);
    chk("sp_mid_dv", 64'(m.DataValid), 64'd0);
    beat("sp1", 32'h1008, 0, D_HI);
    chk("sp_dv",   64'(m.DataValid),  64'd1);
    chk("sp_word", 64'(m.DataWord),   64'h0C0B0A0908070605);
    chk("sp_off",  64'(m.DataOffset), 64'd0);
    step();
    chk("sp_cnt", 64'(m.SplitCount), 64'd1);

    // split lh at 0x1007, beat 1 grant stalled 3 cycles
    start(32'h1007, 2'd1);
    beat("lh0", 32'h1000, 0, D_LO);
    beat("lh1", 32'h1008, 3, D_HI);
    chk("lh_dv",   64'(m.DataValid),  64'd1);
    chk("lh_word", 64'(m.DataWord),   64'h0E0D0C0B0A090807);
    chk("lh_off",  64'(m.DataOffset), 64'd0);
    step();
    chk("lh_cnt", 64'(m.SplitCount), 64'd2);

    // lb at 0x1007 ends exactly at the boundary: not split
    start(32'h1007, 2'd0);
    beat("lb", 32'h1000, 0, 64'h1122334455667788);
    chk("lb_dv",   64'(m.DataValid),  64'd1);
    chk("lb_word", 64'(m.DataWord),   64'h1122334455667788);
    chk("lb_off",  64'(m.DataOffset), 64'd7);
    step();
    chk("lb_cnt", 64'(m.SplitCount), 64'd2);

    // address wrap on the second beat
    start(32'hFFFF_FFFD, 2'd3);
    beat("wr0", 32'hFFFF_FFF8, 0, D_LO);
    beat("wr1", 32'h0000_0000, 0, D_HI);
    chk("wr_word", 64'(m.DataWord), 64'h0C0B0A0908070605);
    step();
    chk("wr_cnt", 64'(m.SplitCount), 64'd3);

    // flush while beat-1 response pending -> DRAIN until response
    start(32'h1005, 2'd3);
    beat("fl0", 32'h1000, 0, D_LO);
    chk("fl_adr1", 64'(m.MemAdr), 64'h1008);
    m.MemGnt = 1'b1;
    step();
    m.MemGnt = 1'b0;
    m.Flush  = 1'b1;
    step();
    m.Flush  = 1'b0;
    chk("fl_drain_req",   64'(m.MemReq),    64'd0);
    chk("fl_drain_ready", 64'(m.LoadReady), 64'd0);
    chk("fl_drain_dv",    64'(m.DataValid), 64'd0);
    step();
    chk("fl_drain_ready2", 64'(m.LoadReady), 64'd0);
    chk("fl_drain_dv2",    64'(m.DataValid), 64'd0);
    m.MemRspValid = 1'b1;
    m.MemRspData  = D_HI;
    step();
    m.MemRspValid = 1'b0;
    chk("fl_ready", 64'(m.LoadReady),  64'd1);
    chk("fl_dv",    64'(m.DataValid),  64'd0);
    chk("fl_cnt",   64'(m.SplitCount), 64'd3);

    // flush in REQ without grant -> straight back to IDLE
    start(32'h2000, 2'd2);
    m.Flush = 1'b1;
    step();
    m.Flush = 1'b0;
    chk("flq_ready", 64'(m.LoadReady), 64'd1);
    chk("flq_req",   64'(m.MemReq),    64'd0);
    chk("flq_dv",    64'(m.DataValid), 64'd0);

    // Flush together with LoadValid accepts nothing
    m.LoadValid = 1'b1;
    m.Flush     = 1'b1;
    m.LoadAdr   = 32'h2000;
    m.LoadSize  = 2'd2;
    step();
    m.LoadValid = 1'b0;
    m.Flush     = 1'b0;
    chk("fli_ready", 64'(m.LoadReady), 64'd1);
    chk("fli_req",   64'(m.MemReq),    64'd0);

    // reset with a beat outstanding; late response ignored
    start(32'h2000, 2'd2);
    m.MemGnt = 1'b1;
    step();
    m.MemGnt = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mr_ready", 64'(m.LoadReady),  64'd1);
    chk("mr_req",   64'(m.MemReq),     64'd0);
    chk("mr_adr",   64'(m.MemAdr),     64'd0);
    chk("mr_dv",    64'(m.DataValid),  64'd0);
    chk("mr_word",  64'(m.DataWord),   64'd0);
    chk("mr_err",   64'(m.DataErr),    64'd0);
    chk("mr_cnt",   64'(m.SplitCount), 64'd0);
    m.MemRspValid = 1'b1;
    m.MemRspData  = 64'hDEADBEEFCAFEF00D;
    step();
    m.MemRspValid = 1'b0;
    chk("mr_late_ready", 64'(m.LoadReady), 64'd1);
    chk("mr_late_dv",    64'(m.DataValid), 64'd0);
    chk("mr_late_word",  64'(m.DataWord),  64'd0);

    // saturation: preload the counter just below the limit
    force dut.split_count = 16'hFFFE;
    #1;
    release dut.split_count;
    chk("sat_preload", 64'(m.SplitCount), 64'hFFFE);
    start(32'h1005, 2'd3);
    beat("sa0", 32'h1000, 0, D_LO);
    beat("sa1", 32'h1008, 0, D_HI);
    step();
    chk("sat_cnt_max", 64'(m.SplitCount), 64'hFFFF);
    start(32'h1005, 2'd3);
    beat("sb0", 32'h1000, 0, D_LO);
    beat("sb1", 32'h1008, 0, D_HI);
    chk("sat_dv", 64'(m.DataValid), 64'd1);
    step();
    chk("sat_cnt_hold", 64'(m.SplitCount), 64'hFFFF);

    // illegal: 8-byte load on a 32-bit sequencer
    n.LoadValid = 1'b1;
    n.LoadAdr   = 32'h100;
    n.LoadSize  = 2'd3;
    step();
    n.LoadValid = 1'b0;
    chk("il_dv",    64'(n.DataValid), 64'd1);
    chk("il_err",   64'(n.DataErr),   64'd1);
    chk("il_word",  64'(n.DataWord),  64'd0);
    chk("il_req",   64'(n.MemReq),    64'd0);
    chk("il_busy",  64'(n.LoadReady), 64'd0);
    step();
    chk("il_dv_end", 64'(n.DataValid),  64'd0);
    chk("il_ready",  64'(n.LoadReady),  64'd1);
    chk("il_req2",   64'(n.MemReq),     64'd0);
    chk("il_cnt",    64'(n.SplitCount), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/misaligned_load_seq.md
# misaligned_load_seq

Sequences misaligned loads for the LSU. A load whose bytes cross an LLEN/8-byte boundary is split into two aligned memory beats, and the two beats are merged into one LLEN-bit word. Loads that fit in one beat pass through as a single beat. The output word and offset drive subword extraction and sign extension directly.

## Interface
Parameters:
- LLEN, 64: load data width in bits, 32/64/128; beat size B = LLEN/8 bytes.
- ADRW, 32: physical byte-address width.
- OFFW, $clog2(LLEN/8): width of the in-beat byte offset.

Ports (clock is clk, reset is reset; reset is synchronous and active-high):
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- LoadValid  in  1  load request; accepted when LoadValid & LoadReady.
- LoadReady  out  1  sequencer idle, can accept a request.
- LoadAdr  in  ADRW  byte address of the load.
- LoadSize  in  2  log2 of access bytes (Funct3[1:0]).
- Flush  in  1  abort the current load.
- MemReq  out  1  memory beat request.
- MemAdr  out  ADRW  beat address, always B-aligned.
- MemGnt  in  1  memory accepted the beat this cycle.
- MemRspValid  in  1  beat data valid.
- MemRspData  in  LLEN  beat data.
- DataValid  out  1  one-cycle pulse: DataWord/DataOffset/DataErr valid.
- DataWord  out  LLEN  merged load word.
- DataOffset  out  OFFW  byte offset for subword extraction.
- DataErr  out  1  request was illegal; no memory access was made.
- SplitCount  out  16  saturating count of split loads completed.

## Operation
- States: IDLE, REQ, RSP, DONE, DRAIN.
- Decode is done at acceptance: off = LoadAdr[OFFW-1:0], nbytes = 1<<LoadSize.
  - Split when off + nbytes > B.
  - Illegal when nbytes > B. An illegal request goes IDLE→DONE with DataErr=1, DataWord=0 and no MemReq.
- IDLE: LoadReady=1. On acceptance, latch the address, size and split flag; set beat=0; go to REQ.
- REQ: MemReq=1, with MemAdr = {LoadAdr[ADRW-1:OFFW], 0} + beat·B, taken modulo 2^ADRW (the top address wraps to 0). On MemGnt, go to RSP.
- RSP: wait for MemRspValid.
  - If this is beat 0 and the load is split: capture MemRspData into lo register, set beat=1, go to REQ.
  - Otherwise, form the output and go to DONE.
- Output formation:
  - Unsplit: DataWord = MemRspData, DataOffset = off.
  - Split: DataWord = low LLEN bits of ({MemRspData, lo} >> 8·off), DataOffset = 0. Byte order is little-endian.
- DONE: DataValid=1 for exactly one cycle. SplitCount increments if the load was split, saturating at 0xFFFF. Next state is IDLE.
- Flush:
  - In REQ with no MemGnt that cycle: go to IDLE.
  - In REQ with MemGnt, or in RSP: go to DRAIN.
  - In DONE: ignored; the pulse is still produced.
  - In IDLE: ignored, and Flush & LoadValid in the same cycle accepts nothing.
  - No DataValid is ever produced for a flushed load.
- DRAIN: MemReq=0. Discard the next MemRspValid, then go to IDLE. Flush has no further effect in DRAIN.
- MemRspValid is ignored in IDLE, REQ and DONE.
- At most one beat is outstanding at any time.

## Timing
- Reset values:
  - State IDLE, LoadReady=1.
  - MemReq=0, MemAdr=0.
  - DataValid=0, DataWord=0, DataOffset=0, DataErr=0.
  - SplitCount=0, lo=0.
- Reset in any state, including with a beat outstanding, returns to IDLE the next cycle. Stale responses then fall under the "ignored in IDLE" rule.
- All outputs are registered or decoded from state only; there is no combinational path from Mem* inputs to Mem* outputs.
- MemReq and MemAdr stay stable until MemGnt. MemRspValid arrives no earlier than the cycle after MemGnt.
- Single beat with zero-wait memory: accept at cycle 0 → MemReq in cycles 1 → response in cycle 2 → DataValid in cycle 3 → LoadReady in cycle 4.
- A split load adds 2 cycles plus any memory wait.
- Illegal request: DataValid (with DataErr=1) the cycle after acceptance.

## Test plan
- Aligned: LLEN=64, lw at 0x1004. Expect one MemReq with MemAdr=0x1000. Respond 0x1122334455667788 → DataWord=0x1122334455667788, DataOffset=4, DataValid in cycle 3, SplitCount=0.
- Split: ld at 0x1005. Expect MemAdr 0x1000 then 0x1008. Respond 0x0706050403020100 then 0x0F0E0D0C0B0A0908 → DataWord=0x0C0B0A0908070605, DataOffset=0, SplitCount=1.
- Split lh at 0x1007, same responses → DataWord=0x0E0D0C0B0A090807. Stall MemGnt 3 cycles on beat 1; MemAdr must hold 0x1008 throughout.
- Wrap: ld at 0xFFFFFFFD → MemAdr 0xFFFFFFF8 then 0x00000000.
- Flush while the beat-1 response is pending → no DataValid; state is DRAIN until MemRspValid, then LoadReady=1. Also apply reset mid-RSP → all outputs at reset values the next cycle, and a late MemRspValid is ignored.
- Illegal: LLEN=32, LoadSize=3 → no MemReq; DataValid with DataErr=1 one cycle after acceptance. Preloading 0xFFFF split loads, then one more split load → SplitCount stays 0xFFFF.
